// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches 4 bytes per instruction from a byte-wide synchronous memory,
// assembles them big-endian and hands them off over a valid/ready handshake.
module instr_fetch_unit #(
    parameter int ADDR_W = 7,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [31:0]       instr,
    output logic [31:0]       pc_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              done
);
    typedef enum logic [1:0] {FETCH, HOLD, DONE} state_t;
    localparam logic [31:0] LIMIT = 32'((1 << ADDR_W) - 4);
    state_t      state;
    logic [31:0] pc;
    logic [1:0]  cnt;
    logic [1:0]  cap;
    logic        issued;
    logic        tag;
    logic [31:0] new_pc;
    logic [31:0] next_pc;
    assign new_pc   = redirect_pc & ~32'd3;
    assign next_pc  = pc + 32'd4;
    assign mem_en   = (state == FETCH) & ~issued & ~rst;
    assign mem_addr = pc[ADDR_W-1:0] + {{(ADDR_W-2){1'b0}}, cnt};
    assign pc_out   = pc;
    assign done     = state == DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            state       <= (RESET_PC > LIMIT) ? DONE : FETCH;
            cnt         <= '0;
            cap         <= '0;
            issued      <= 1'b0;
            tag         <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else if (redirect_valid) begin
            // Clearing the tag discards the byte still returning for the aborted fetch
            pc          <= new_pc;
            state       <= (new_pc > LIMIT) ? DONE : FETCH;
            cnt         <= '0;
            cap         <= '0;
            issued      <= 1'b0;
            tag         <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    tag <= mem_en;
                    if (mem_en) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) issued <= 1'b1;
                    end
                    if (tag) begin
                        instr <= {instr[23:0], mem_rdata};
                        cap   <= cap + 2'd1;
                        if (cap == 2'd3) begin
                            state       <= HOLD;
                            instr_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc          <= next_pc;
                        state       <= (next_pc > LIMIT) ? DONE : FETCH;
                        cnt         <= '0;
                        cap         <= '0;
                        issued      <= 1'b0;
                        instr_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch timing, backpressure, redirect, window end and reset.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic [7:0]  mem [128];
    logic        rst, mem_en, instr_valid, instr_ready, redirect_valid, done;
    logic [6:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic [31:0] instr, pc_out, redirect_pc;
    logic        rst1, mem_en1, instr_valid1, instr_ready1, redirect_valid1, done1;
    logic [6:0]  mem_addr1;
    logic [7:0]  mem_rdata1;
    logic [31:0] instr1, pc_out1, redirect_pc1;
    int checks = 0;
    int errs = 0;
    logic [31:0] held_instr;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(7), .RESET_PC(32'h0)) u0 (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .instr(instr), .pc_out(pc_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .done(done));

    instr_fetch_unit #(.ADDR_W(7), .RESET_PC(32'h78)) u1 (
        .clk(clk), .rst(rst1), .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1),
        .instr(instr1), .pc_out(pc_out1), .instr_valid(instr_valid1), .instr_ready(instr_ready1),
        .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1), .done(done1));

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
        if (mem_en1) mem_rdata1 <= mem[mem_addr1];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // bytes 0..7 fixed; elsewhere byte = addr ^ 0xA5
        for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[0] = 8'h01; mem[1] = 8'h23; mem[2] = 8'h45; mem[3] = 8'h67;
        mem[4] = 8'h89; mem[5] = 8'hAB; mem[6] = 8'hCD; mem[7] = 8'hEF;
        rst = 1; instr_ready = 1; redirect_valid = 0; redirect_pc = 0;
        rst1 = 1; instr_ready1 = 1; redirect_valid1 = 0; redirect_pc1 = 0;
        step(); step();
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
        chk("rst1_pc", pc_out1, 32'h78);
        chk("rst1_done", {31'b0, done1}, 32'h0);
        // sequence from PC 0
        rst = 0;
        #1;
        chk("f0_mem_en", {31'b0, mem_en}, 32'h1);
        chk("f0_addr", {25'b0, mem_addr}, 32'h0);
        repeat (4) step();
        chk("f4_valid", {31'b0, instr_valid}, 32'h0);
        step();
        chk("i0_valid", {31'b0, instr_valid}, 32'h1);
        chk("i0_instr", instr, 32'h01234567);
        chk("i0_pc", pc_out, 32'h0);
        repeat (6) step();
        chk("i1_valid", {31'b0, instr_valid}, 32'h1);
        chk("i1_instr", instr, 32'h89ABCDEF);
        chk("i1_pc", pc_out, 32'h4);
        // backpressure
        instr_ready = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_state", {instr_valid, mem_en, 30'b0} ^ pc_out, {1'b1, 31'b0} ^ 32'h4);
            chk("bp_instr", instr, 32'h89ABCDEF);
        end
        instr_ready = 1;
        step();
        chk("bp_rel_valid", {31'b0, instr_valid}, 32'h0);
        chk("bp_rel_pc", pc_out, 32'h8);
        repeat (5) step();
        chk("i2_instr", instr, 32'hADACAFAE);
        chk("i2_pc", pc_out, 32'h8);
        // transfer and redirect on the same edge
        redirect_valid = 1; redirect_pc = 32'h40;
        step();
        redirect_valid = 0;
        chk("sim_pc", pc_out, 32'h40);
        chk("sim_valid", {31'b0, instr_valid}, 32'h0);
        chk("sim_addr", {25'b0, mem_addr}, 32'h40);
        repeat (5) step();
        chk("i40_instr", instr, 32'hE5E4E7E6);
        chk("i40_pc", pc_out, 32'h40);
        // reset while holding
        instr_ready = 0; rst = 1;
        step();
        rst = 0;
        chk("rh_valid", {31'b0, instr_valid}, 32'h0);
        chk("rh_pc", pc_out, 32'h0);
        // redirect during F2 of fetch at PC 0
        step(); step();
        redirect_valid = 1; redirect_pc = 32'h12;
        step();
        redirect_valid = 0;
        chk("rd_pc", pc_out, 32'h10);
        chk("rd_valid", {31'b0, instr_valid}, 32'h0);
        repeat (4) step();
        chk("rd_f4_valid", {31'b0, instr_valid}, 32'h0);
        step();
        chk("rd_valid2", {31'b0, instr_valid}, 32'h1);
        chk("rd_instr", instr, 32'hB5B4B7B6);
        chk("rd_pc2", pc_out, 32'h10);
        // end of window on the RESET_PC=0x78 instance
        rst1 = 0;
        repeat (5) step();
        chk("w0_instr", instr1, 32'hDDDCDFDE);
        chk("w0_pc", pc_out1, 32'h78);
        repeat (6) step();
        chk("w1_instr", instr1, 32'hD9D8DBDA);
        chk("w1_pc", pc_out1, 32'h7C);
        chk("w1_done", {31'b0, done1}, 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("w_done", {31'b0, done1}, 32'h1);
            chk("w_mem_en", {31'b0, mem_en1}, 32'h0);
            step();
        end
        redirect_valid1 = 1; redirect_pc1 = 32'h0;
        step();
        redirect_valid1 = 0;
        chk("wr_done", {31'b0, done1}, 32'h0);
        chk("wr_mem_en", {31'b0, mem_en1}, 32'h1);
        chk("wr_addr", {25'b0, mem_addr1}, 32'h0);
        repeat (5) step();
        chk("wr_instr", instr1, 32'h01234567);
        chk("wr_valid", {31'b0, instr_valid1}, 32'h1);
        held_instr = instr;
        chk("rd_hold_final", held_instr, 32'hB5B4B7B6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage placed directly upstream of `R_FormatCPU`. It holds the program counter and reads four consecutive bytes from a byte-wide, synchronous-read instruction memory. It assembles them big-endian into a 32-bit instruction and presents the instruction with its PC to the CPU over a valid/ready handshake. It advances the PC by 4 per accepted instruction, accepts a redirect (new PC) at any time, and raises `done` once the PC leaves the instruction window.

## Interface
- `ADDR_W`, 7: byte-address width; instruction window `ADDR_MAX` = 2^ADDR_W bytes (128).
- `RESET_PC`, 0: PC loaded on reset; must be word aligned.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_en`  out  1  memory read strobe.
- `mem_addr`  out  ADDR_W  byte address for the memory read.
- `mem_rdata`  in  8  read data, valid the cycle after the `mem_en` cycle.
- `instr`  out  32  assembled instruction; byte at PC is bits 31:24.
- `pc_out`  out  32  byte address of `instr`.
- `instr_valid`  out  1  `instr`/`pc_out` hold a complete instruction.
- `instr_ready`  in  1  consumer accepts the instruction this edge.
- `redirect_valid`  in  1  load a new PC.
- `redirect_pc`  in  32  new PC; bits 1:0 ignored (forced 0).
- `done`  out  1  PC > ADDR_MAX-4; no further fetches.

## Operation
- States:
  - FETCH: issues bytes 0..3 via a 2-bit issue counter.
  - HOLD: `instr_valid`=1, waiting for `instr_ready`.
  - DONE: idle, `done`=1.
- FETCH, issue: for k=0..3 on consecutive cycles, drive `mem_en`=1 and `mem_addr`=pc+k.
- FETCH, capture:
  - A 1-bit tag pipeline marks which `mem_rdata` cycles belong to the current fetch.
  - Each tagged byte is shifted into the `instr` assembly register, MSB first.
  - After byte 3 is captured, go to HOLD.
- HOLD: on an edge with `instr_valid`&`instr_ready`, the transfer occurs.
  - pc <= pc+4.
  - If pc+4 > ADDR_MAX-4, go to DONE; otherwise go to FETCH and clear the issue counter.
- `instr` and `pc_out` are stable throughout HOLD. They change only after a transfer or a redirect.
- Redirect has priority over every other event, in any state including DONE.
  - pc <= {redirect_pc[31:2],2'b00}, and all in-flight tags are cleared.
  - Bytes returned for the aborted fetch are discarded.
  - Next state is FETCH, or DONE if the new PC > ADDR_MAX-4.
  - `instr_valid` is 0 from the next cycle.
- Transfer and redirect on the same edge: the transfer counts as consumed, and PC takes the redirect value, not pc+4.
- `done` is 1 exactly in DONE. `mem_en` is 0 in HOLD and DONE.
- PC arithmetic is 32-bit unsigned. `mem_addr` is the low ADDR_W bits of pc+k; no wrap occurs because the PC is never beyond ADDR_MAX-4 while fetching.

## Timing
- Reset values, in the cycle after the reset edge:
  - pc=`RESET_PC`, state FETCH, issue counter 0, tags 0.
  - `instr`=0, `pc_out`=`RESET_PC`, `instr_valid`=0.
  - `done`=0, or 1 if `RESET_PC` > ADDR_MAX-4.
- Output timing while `rst` is high: `mem_en`=0 and all outputs hold their reset values.
- `rst` has priority over redirect and transfer.
- Fetch latency, with F0 as the first FETCH cycle:
  - Addresses are issued in F0..F3.
  - Data is captured at the ends of F1..F4.
  - `instr_valid`=1 from F5.
- Throughput: with `instr_ready` held 1, one instruction every 6 cycles. The transfer is at the end of F5, and the next F0 is the following cycle.
- Reset mid-fetch: all progress is lost, and the fetch restarts at `RESET_PC` after `rst` falls.
- `instr_ready` is ignored when `instr_valid`=0.

## Test plan
- Reset and sequence:
  - Stimulus: memory bytes 0..7 = 01 23 45 67 89 AB CD EF, `instr_ready`=1.
  - Response: `instr`=0x01234567, `pc_out`=0, valid in cycle 5 after reset release; then 0x89ABCDEF, `pc_out`=4, valid in cycle 11.
- Backpressure:
  - Stimulus: hold `instr_ready`=0 for 10 cycles after valid.
  - Response: `instr`, `pc_out` and `instr_valid` stay constant and `mem_en`=0; the release edge transfers exactly once.
- Redirect mid-fetch:
  - Stimulus: assert `redirect_pc`=0x12 during F2 of the fetch at PC 0.
  - Response: the next valid instruction has `pc_out`=0x10 and holds bytes 0x10..0x13; no byte from address 0..2 appears.
- Simultaneous transfer and redirect:
  - Stimulus: handshake at PC 8 on the same edge as `redirect_pc`=0x40.
  - Response: the next `pc_out`=0x40, not 0xC.
- End of window:
  - Stimulus: `RESET_PC`=0x78, `instr_ready`=1.
  - Response: `pc_out`=0x78, then 0x7C; after the 0x7C transfer, `done`=1 and `mem_en` stays 0; a redirect to 0 restarts fetching.
- Reset mid-HOLD:
  - Stimulus: assert `rst` for one cycle while `instr_valid`=1.
  - Response: next cycle `instr_valid`=0 and `pc_out`=`RESET_PC`.
